// File: rtl/weight_feeder_if.sv
// Weight-feeder bus: the host write stream plus the PE weight request/return path.
interface weight_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_bank;
  logic [DATA_W-1:0] wr_data;
  logic              weight_in_valid;
  logic [ADDR_W-1:0] weight_addr;
  logic [DATA_W-1:0] weight_out;
  logic              weight_out_valid;

  // Feeder side
  modport slave (
    input  wr_valid, wr_bank, wr_data, weight_in_valid, weight_addr,
    output wr_ready, weight_out, weight_out_valid
  );

  // Host / PE controller side
  modport master (
    output wr_valid, wr_bank, wr_data, weight_in_valid, weight_addr,
    input  wr_ready, weight_out, weight_out_valid
  );
endinterface

// File: rtl/weight_feeder.sv
// Weight feeder: three 9-word weight banks filled by a host stream and read
// by the PE controller with a fixed one-cycle latency.
module weight_feeder #(
  parameter int DATA_W   = 8,
  parameter int NUM_TAPS = 9,
  parameter int ADDR_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mod,
  weight_feeder_if.slave  bus,
  output logic [2:0]      bank_loaded,
  output logic            addr_err
);

  localparam int PTR_W = $clog2(NUM_TAPS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NUM_TAPS - 1);

  logic [DATA_W-1:0] mem [3][NUM_TAPS];
  logic [PTR_W-1:0]  ptr [3];
  logic [1:0]        sel;
  logic              mod_ok;
  logic              addr_ok;
  logic              wr_fire;

  // One-hot mode decode; anything else selects no bank.
  always_comb begin
    sel    = 2'd0;
    mod_ok = 1'b1;
    case (mod)
      3'b001:  sel = 2'd0;
      3'b010:  sel = 2'd1;
      3'b100:  sel = 2'd2;
      default: mod_ok = 1'b0;
    endcase
  end

  assign addr_ok = (bus.weight_addr <= LAST_TAP);

  // Reads win: the bank being read this cycle refuses host words, so a read
  // never observes a same-cycle write.
  assign bus.wr_ready = (bus.wr_bank != 2'd3) &&
                        !(bus.weight_in_valid && mod_ok && (bus.wr_bank == sel));
  assign wr_fire      = bus.wr_valid && bus.wr_ready;

  // Host write path: per-bank pointer, loaded flag set on the last tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        ptr[b] <= '0;
        for (int t = 0; t < NUM_TAPS; t++) mem[b][t] <= '0;
      end
      bank_loaded <= '0;
    end else if (wr_fire) begin
      mem[bus.wr_bank][ptr[bus.wr_bank]] <= bus.wr_data;
      if (ptr[bus.wr_bank] == '0)
        bank_loaded[bus.wr_bank] <= 1'b0;
      if (ptr[bus.wr_bank] == LAST_PTR) begin
        ptr[bus.wr_bank]         <= '0;
        bank_loaded[bus.wr_bank] <= 1'b1;
      end else begin
        ptr[bus.wr_bank] <= ptr[bus.wr_bank] + 1'b1;
      end
    end
  end

  // Read path: out-of-range address is checked ahead of the mode check.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.weight_out       <= '0;
      bus.weight_out_valid <= 1'b0;
      addr_err             <= 1'b0;
    end else if (bus.weight_in_valid) begin
      if (!addr_ok) begin
        bus.weight_out       <= '0;
        bus.weight_out_valid <= 1'b1;
        addr_err             <= 1'b1;
      end else if (!mod_ok) begin
        bus.weight_out       <= '0;
        bus.weight_out_valid <= 1'b0;
      end else begin
        bus.weight_out       <= bank_loaded[sel] ? mem[sel][bus.weight_addr] : '0;
        bus.weight_out_valid <= 1'b1;
      end
    end else begin
      bus.weight_out_valid <= 1'b0;
    end
  end

endmodule
